fetch_prefetch: RTL
===================

Name: fetch_prefetch

Overview:
Parametrised instruction-fetch front end for the core. Replaces the single-command fetch latch with a DEPTH-entry prefetch queue. Adds zero-bubble static branch prediction on returning instruction words and a flush/redirect path from execute. Sits between the synchronous instruction BRAM (1-cycle read latency) and decode, and hands decode {pc, command, prediction} through a valid/ready handshake.

Parameters:
ADDR_W, 16, instruction word-address width; inst_addr = pc[ADDR_W+1:2]
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 32'h00000000, first fetch address after reset
PREDICT, 1, 1 = static prediction enabled; 0 = purely sequential fetch

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
redirect_valid  in  1  execute-side pc correction (mispredict, jr, exception)
redirect_pc  in  32  corrected pc; word aligned
inst_enable  out  1  BRAM read strobe, high in every issue cycle
inst_addr  out  ADDR_W  BRAM word address
inst_data  in  32  BRAM read data, valid the cycle after issue
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  32  pc of head instruction
out_command  out  32  head instruction word
out_pred_taken  out  1  head was predicted taken
out_pred_target  out  32  predicted target of head (pc+4 if not taken)

Behaviour:
- Reset (async, rstn low): queue count 0, out_valid 0, inst_enable 0, resp_pending 0, fpc = RESET_PC. All out_* data are 0.
- State: fpc (next sequential fetch pc), resp_pending/resp_pc (read issued last cycle), circular queue with rd/wr pointers and a count of width clog2(DEPTH)+1.
- Issue condition: count + resp_pending < DEPTH, or redirect_valid. The pop of the current cycle is ignored, so the check is conservative. inst_enable = issue.
- Next address na, by priority:
  - redirect_valid: redirect_pc.
  - else resp_pending and PREDICT and the returning inst_data is predicted taken: its target.
  - else: fpc.
- inst_addr = na[ADDR_W+1:2]. If issue: fpc <= na+4, resp_pending <= 1, resp_pc <= na. Else: fpc <= na, resp_pending <= 0.
- Prediction on inst_data at pc P, first match wins:
  - [31:27]==5'b00001 (J/JAL): taken, target {4'b0000,[25:0],2'b00}.
  - [31:26]==6'b110010 (BC): taken, target P + sext({[25:0],2'b00}).
  - [31:27]==5'b00010 and [15]==1 (backward BEQ/BNE): taken, target P + sext({[15:0],2'b00}).
  - Otherwise not taken, target P+4.
- Prediction is combinational from inst_data to inst_addr: zero bubble, no wrong-path fetch.
- Push: when resp_pending and no redirect, write {resp_pc, inst_data, taken, target} at wr pointer.
- Pop: when out_valid and out_ready and no redirect.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Redirect: count <= 0, pointers reset, in-flight response discarded (no push), pop ignored, out_valid low next cycle. A fresh issue at redirect_pc happens the same cycle. The first redirected instruction reaches out_valid 2 cycles after redirect.
- Back-to-back redirects: the latest wins, with no stale push.
- Queue full: no issue. fpc holds, or takes the predicted target from the final response. No data loss; the response pushed while full is impossible by the issue rule.
- PREDICT=0: out_pred_taken is always 0 and out_pred_target is always pc+4.
- Addresses wrap mod 2^32; inst_addr drops upper bits.

Test Plan:
- Reset release, out_ready=1, BRAM filled with non-branches → inst_addr 0,1,2,… each cycle; out_pc 0,4,8,… with out_valid from cycle 2 onward, one per cycle.
- out_ready=0 with DEPTH=4 → exactly 4 entries queued, inst_enable low afterward, fpc=0x10. Releasing out_ready → pcs 0,4,8,C then 10 with no gap or duplicate.
- Word at 0x8 = J with [25:0]=0x40 → next inst_addr 0x40 (pc 0x100) in the same cycle inst_data returns; queue holds 0x8 (pred_taken=1, target 0x100) then 0x100; no 0xC.
- Word at 0x20 = BNE, imm 0xFFFE → target 0x18, loop fetched repeatedly. Word at 0x20 = BEQ, imm 0x0002 → not taken, 0x24 follows.
- Queue holding 3 entries plus a pending read, redirect_valid with redirect_pc=0x200 → out_valid 0 next cycle, old pending data never appears, out_pc 0x200 two cycles later.
- Assert rstn low mid-stream with full queue → out_valid and inst_enable drop immediately; after release, fetch restarts at RESET_PC.
- PREDICT=0 with J at 0x8 → sequential 0xC fetched, out_pred_taken=0.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: DEPTH-entry prefetch queue between a 1-cycle BRAM
// and decode, with zero-bubble static branch prediction and an execute redirect.
module fetch_prefetch #(
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          PREDICT  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_enable,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_command,
  output logic              out_pred_taken,
  output logic [31:0]       out_pred_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  // Returns {taken, target} for an instruction word fetched from pc.
  function automatic logic [32:0] predict_fn(input logic [31:0] inst, input logic [31:0] pc);
    logic [32:0] res;
    if (inst[31:27] == 5'b00001) begin
      res = {1'b1, 4'b0000, inst[25:0], 2'b00};
    end else if (inst[31:26] == 6'b110010) begin
      res = {1'b1, pc + {{4{inst[25]}}, inst[25:0], 2'b00}};
    end else if ((inst[31:27] == 5'b00010) && inst[15]) begin
      res = {1'b1, pc + {{14{inst[15]}}, inst[15:0], 2'b00}};
    end else begin
      res = {1'b0, pc + 32'd4};
    end
    return res;
  endfunction

  logic          started_r;
  logic [31:0]   fpc_r;
  logic          resp_pending_r;
  logic [31:0]   resp_pc_r;
  logic [PW-1:0] rd_r;
  logic [PW-1:0] wr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   cmd_q  [DEPTH];
  logic          tk_q   [DEPTH];
  logic [31:0]   tg_q   [DEPTH];

  logic [32:0]   pred_s;
  logic [CW:0]   occ_s;
  logic          issue_s;
  logic [31:0]   na_s;
  logic          push_s;
  logic          pop_s;

  // Next-address selection; the returning word's prediction steers this cycle's read.
  always_comb begin
    pred_s  = PREDICT ? predict_fn(inst_data, resp_pc_r) : {1'b0, resp_pc_r + 32'd4};
    occ_s   = {1'b0, count_r} + {{CW{1'b0}}, resp_pending_r};
    issue_s = started_r & (redirect_valid | (occ_s < DEPTH_L));
    if (redirect_valid) begin
      na_s = redirect_pc;
    end else if (resp_pending_r && pred_s[32]) begin
      na_s = pred_s[31:0];
    end else begin
      na_s = fpc_r;
    end
    push_s = resp_pending_r & ~redirect_valid;
    pop_s  = out_valid & out_ready & ~redirect_valid;
  end

  assign inst_enable     = issue_s;
  assign inst_addr       = na_s[ADDR_W+1:2];
  assign out_valid       = (count_r != '0);
  assign out_pc          = pc_q[rd_r];
  assign out_command     = cmd_q[rd_r];
  assign out_pred_taken  = tk_q[rd_r];
  assign out_pred_target = tg_q[rd_r];

  // Fetch pc, read-in-flight tracking and the circular queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started_r      <= 1'b0;
      fpc_r          <= RESET_PC;
      resp_pending_r <= 1'b0;
      resp_pc_r      <= 32'd0;
      rd_r           <= '0;
      wr_r           <= '0;
      count_r        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= 32'd0;
        cmd_q[i] <= 32'd0;
        tk_q[i]  <= 1'b0;
        tg_q[i]  <= 32'd0;
      end
    end else begin
      started_r      <= 1'b1;
      fpc_r          <= issue_s ? (na_s + 32'd4) : na_s;
      resp_pending_r <= issue_s;
      resp_pc_r      <= issue_s ? na_s : resp_pc_r;
      if (redirect_valid) begin
        rd_r    <= '0;
        wr_r    <= '0;
        count_r <= '0;
      end else begin
        if (push_s) begin
          pc_q[wr_r]  <= resp_pc_r;
          cmd_q[wr_r] <= inst_data;
          tk_q[wr_r]  <= pred_s[32];
          tg_q[wr_r]  <= pred_s[31:0];
          wr_r        <= wr_r + PW'(1);
        end
        if (pop_s) begin
          rd_r <= rd_r + PW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule
